// File: rtl/io_flash_memory_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_flash_pkg
// Purpose  : Shared IO word field positions and the response FIFO entry type
//            for io_flash_memory_bank.
// Revision : 1.0  initial release
// ============================================================================
package io_flash_pkg;

  localparam int c_IO_WORD_W   = 32;
  localparam int c_AUTOINC_BIT = 31;
  localparam int c_WDATA_LSB   = 0;
  // Address field starts at DATA_W; the module computes that offset itself.
  localparam int c_TAG_MAX_W   = 8;

  // Entries are stored zero-extended to the IO word so the response path needs no
  // further widening; the bank instantiation must keep DEST_W <= c_TAG_MAX_W.
  typedef struct packed {
    logic [c_TAG_MAX_W-1:0] tag;
    logic [c_IO_WORD_W-1:0] data;
  } io_resp_t;

endpackage
`default_nettype wire

// File: rtl/io_flash_memory_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : io_flash_memory_bank_if
// Purpose  : Core IO out/in channel between a core (master) and the bank (slave).
// Revision : 1.0  initial release
// ============================================================================
interface io_flash_memory_bank_if
  import io_flash_pkg::*;
#(
  parameter int DEST_W = 4
);
  logic                   IOOut_ACK;
  logic                   IOOut_REQ;
  logic                   IOOut_ResponseRequested;
  logic [DEST_W-1:0]      IOOut_DestReg;
  logic [c_IO_WORD_W-1:0] IOOut_Data;
  logic                   IOIn_ACK;
  logic                   IOIn_REQ;
  logic                   IOIn_RegResponseFlag;
  logic                   IOIn_MemResponseFlag;
  logic [DEST_W-1:0]      IOIn_DestReg;
  logic [c_IO_WORD_W-1:0] IOIn_Data;

  modport master (
    output IOOut_ACK, IOOut_ResponseRequested, IOOut_DestReg, IOOut_Data, IOIn_REQ,
    input  IOOut_REQ, IOIn_ACK, IOIn_RegResponseFlag, IOIn_MemResponseFlag,
           IOIn_DestReg, IOIn_Data
  );

  modport slave (
    input  IOOut_ACK, IOOut_ResponseRequested, IOOut_DestReg, IOOut_Data, IOIn_REQ,
    output IOOut_REQ, IOIn_ACK, IOIn_RegResponseFlag, IOIn_MemResponseFlag,
           IOIn_DestReg, IOIn_Data
  );
endinterface
`default_nettype wire

// File: rtl/io_flash_memory_bank_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : io_resp_fifo
// Purpose  : DEPTH-entry synchronous FIFO of io_resp_t with occupancy output.
// Revision : 1.0  initial release
// ============================================================================
module io_resp_fifo
  import io_flash_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     i_push,
  input  wire io_resp_t                 i_pushData,
  input  wire logic                     i_pop,
  output      io_resp_t                 o_head,
  output      logic                     o_empty,
  output      logic [$clog2(DEPTH):0]   o_count
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  io_resp_t             r_entries [DEPTH];
  logic [c_PTR_W-1:0]   r_wrPtr;
  logic [c_PTR_W-1:0]   r_rdPtr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 w_push;
  logic                 w_pop;

  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && ((r_count != c_CNT_W'(DEPTH)) || w_pop);
  assign o_head  = r_entries[r_rdPtr];
  assign o_count = r_count;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_entries[r_wrPtr] <= i_pushData;
  end

endmodule
`default_nettype wire

// File: rtl/io_flash_memory_bank.sv
`default_nettype none
// ============================================================================
// Module   : io_flash_memory_bank
// Purpose  : IO-mapped memory bank with queued IO read responses and a priority
//            boot/flash read port. Optional feature macro: IO_FLASH_BANK_AUTOINC_EN.
// Revision : 1.0  initial release
// ============================================================================
module io_flash_memory_bank
  import io_flash_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 11,
  parameter int DEST_W     = 4,
  parameter int RESP_DEPTH = 4
) (
  input  wire logic                          clk,
  input  wire logic                          async_rst,
  input  wire logic                          clk_en,
  input  wire logic                          FlashReadEn,
  input  wire logic [ADDR_W-1:0]             FlashAddrIn,
  output      logic [DATA_W-1:0]             FlashData,
  output      logic                          FlashDataValid,
  io_flash_memory_bank_if.slave              io,
  output      logic [$clog2(RESP_DEPTH):0]   RespCount
);
  localparam int c_CNT_W    = $clog2(RESP_DEPTH) + 1;
  localparam int c_ADDR_LSB = DATA_W;

  logic [DATA_W-1:0]  r_mem [2**ADDR_W];
  logic [ADDR_W-1:0]  w_fieldAddr;
  logic [ADDR_W-1:0]  w_ioAddr;
  logic [DATA_W-1:0]  w_wrData;
  logic               w_respRoom;
  logic               w_ioHs;
  logic               w_ioRdHs;
  logic               w_memWe;
  logic               r_inFlight;
  logic [DEST_W-1:0]  r_tag;
  logic [DATA_W-1:0]  r_rdData;
  logic [DATA_W-1:0]  r_flashData;
  logic               r_flashValid;
  logic               w_push;
  logic               w_pop;
  logic               w_fifoEmpty;
  logic [c_CNT_W-1:0] w_fifoCount;
  io_resp_t           w_pushEntry;
  io_resp_t           w_head;
  logic               w_unused;

  assign w_fieldAddr = io.IOOut_Data[c_ADDR_LSB +: ADDR_W];
  assign w_wrData    = io.IOOut_Data[c_WDATA_LSB +: DATA_W];

`ifdef IO_FLASH_BANK_AUTOINC_EN
  logic [ADDR_W-1:0] r_autoPtr;

  assign w_ioAddr = io.IOOut_Data[c_AUTOINC_BIT] ? r_autoPtr : w_fieldAddr;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst)   r_autoPtr <= '0;
    else if (w_ioHs) r_autoPtr <= w_ioAddr + 1'b1;
  end
`else
  assign w_ioAddr = w_fieldAddr;
`endif

  // Occupancy counts the in-flight read so the FIFO can never be overrun,
  // and deliberately ignores a same-cycle pop.
  assign RespCount  = w_fifoCount + {{(c_CNT_W-1){1'b0}}, r_inFlight};
  assign w_respRoom = (RespCount < c_CNT_W'(RESP_DEPTH));

  assign io.IOOut_REQ = clk_en && (io.IOOut_ResponseRequested ? (!FlashReadEn && w_respRoom) : 1'b1);
  assign w_ioHs       = io.IOOut_ACK && io.IOOut_REQ;
  assign w_ioRdHs     = w_ioHs && io.IOOut_ResponseRequested;
  assign w_memWe      = w_ioHs && !io.IOOut_ResponseRequested && !async_rst;

  always_ff @(posedge clk) begin
    if (w_memWe) r_mem[w_ioAddr] <= w_wrData;
    if (w_ioRdHs) begin
      r_tag    <= io.IOOut_DestReg;
      r_rdData <= r_mem[w_ioAddr];
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_inFlight   <= 1'b0;
      r_flashData  <= '0;
      r_flashValid <= 1'b0;
    end else if (clk_en) begin
      r_inFlight   <= w_ioRdHs;
      r_flashValid <= FlashReadEn;
      if (FlashReadEn) r_flashData <= r_mem[FlashAddrIn];
    end
  end

  assign FlashData      = r_flashData;
  assign FlashDataValid = r_flashValid;

  always_comb begin
    w_pushEntry                   = '0;
    w_pushEntry.tag[DEST_W-1:0]   = r_tag;
    w_pushEntry.data[DATA_W-1:0]  = r_rdData;
  end

  assign w_push = r_inFlight && clk_en;
  assign w_pop  = !w_fifoEmpty && io.IOIn_REQ && clk_en;

  io_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_respFifo (
    .clk        (clk),
    .rst        (async_rst),
    .i_push     (w_push),
    .i_pushData (w_pushEntry),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_empty    (w_fifoEmpty),
    .o_count    (w_fifoCount)
  );

  assign io.IOIn_ACK             = !w_fifoEmpty;
  assign io.IOIn_RegResponseFlag = !w_fifoEmpty;
  assign io.IOIn_MemResponseFlag = 1'b0;
  assign io.IOIn_DestReg         = w_fifoEmpty ? '0 : w_head.tag[DEST_W-1:0];
  assign io.IOIn_Data            = w_fifoEmpty ? '0 : w_head.data;

  assign w_unused = ^{io.IOOut_Data, w_head.tag};

endmodule
`default_nettype wire

// File: tb/tb_io_flash_memory_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_flash_memory_bank
// Purpose  : Directed scenarios plus randomized traffic against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_io_flash_memory_bank;
  import io_flash_pkg::*;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 11;
  localparam int DEST_W     = 4;
  localparam int RESP_DEPTH = 4;
  localparam int CNT_W      = $clog2(RESP_DEPTH) + 1;
`ifdef IO_FLASH_BANK_AUTOINC_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              async_rst;
  logic              clk_en;
  logic              FlashReadEn;
  logic [ADDR_W-1:0] FlashAddrIn;
  logic [DATA_W-1:0] FlashData;
  logic              FlashDataValid;
  logic [CNT_W-1:0]  RespCount;
  int                errors = 0;
  int                checks = 0;

  io_flash_memory_bank_if #(.DEST_W(DEST_W)) ioBus ();

  io_flash_memory_bank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEST_W(DEST_W), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk            (clk),
    .async_rst      (async_rst),
    .clk_en         (clk_en),
    .FlashReadEn    (FlashReadEn),
    .FlashAddrIn    (FlashAddrIn),
    .FlashData      (FlashData),
    .FlashDataValid (FlashDataValid),
    .io             (ioBus.slave),
    .RespCount      (RespCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DEST_W-1:0] tag;
    logic [DATA_W-1:0] data;
    bit                queued;
  } exp_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ioWord(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, logic autoBit);
    logic [31:0] w;
    w = '0;
    w[31] = autoBit;
    w[DATA_W +: ADDR_W] = a;
    w[DATA_W-1:0] = d;
    return w;
  endfunction

  task automatic ioIdle();
    ioBus.IOOut_ACK = 1'b0;
    ioBus.IOOut_ResponseRequested = 1'b0;
    ioBus.IOOut_DestReg = '0;
    ioBus.IOOut_Data = '0;
  endtask

  task automatic driveWrite(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, logic autoBit);
    ioBus.IOOut_ACK = 1'b1;
    ioBus.IOOut_ResponseRequested = 1'b0;
    ioBus.IOOut_DestReg = '0;
    ioBus.IOOut_Data = ioWord(a, d, autoBit);
  endtask

  task automatic driveRead(logic [ADDR_W-1:0] a, logic [DEST_W-1:0] tag, logic autoBit);
    ioBus.IOOut_ACK = 1'b1;
    ioBus.IOOut_ResponseRequested = 1'b1;
    ioBus.IOOut_DestReg = tag;
    ioBus.IOOut_Data = ioWord(a, '0, autoBit);
  endtask

  task automatic doWrite(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, logic autoBit);
    driveWrite(a, d, autoBit);
    step();
    ioIdle();
  endtask

  task automatic applyReset();
    ioIdle();
    ioBus.IOIn_REQ = 1'b0;
    FlashReadEn = 1'b0;
    FlashAddrIn = '0;
    clk_en = 1'b1;
    async_rst = 1'b1;
    step();
    step();
    async_rst = 1'b0;
  endtask

  task automatic test_reset();
    async_rst = 1'b1;
    clk_en = 1'b1;
    FlashReadEn = 1'b0;
    FlashAddrIn = '0;
    ioBus.IOIn_REQ = 1'b0;
    ioIdle();
    #3;
    checks++; if (FlashData !== '0) begin errors++; $display("FAIL rst_flashdata got=%h exp=0", FlashData); end
    checks++; if (FlashDataValid !== 1'b0) begin errors++; $display("FAIL rst_flashvalid got=%b exp=0", FlashDataValid); end
    checks++; if (ioBus.IOIn_ACK !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", ioBus.IOIn_ACK); end
    checks++; if (RespCount !== '0) begin errors++; $display("FAIL rst_count got=%0d exp=0", RespCount); end
    checks++; if (ioBus.IOIn_DestReg !== '0 || ioBus.IOIn_Data !== '0) begin errors++; $display("FAIL rst_iodata got=%h/%h exp=0/0", ioBus.IOIn_DestReg, ioBus.IOIn_Data); end
    checks++; if (ioBus.IOIn_MemResponseFlag !== 1'b0 || ioBus.IOIn_RegResponseFlag !== 1'b0) begin errors++; $display("FAIL rst_flags got=%b%b exp=00", ioBus.IOIn_MemResponseFlag, ioBus.IOIn_RegResponseFlag); end
    step();
    step();
    async_rst = 1'b0;
    #1;
    checks++; if (ioBus.IOOut_REQ !== 1'b1) begin errors++; $display("FAIL rst_req_wr got=%b exp=1", ioBus.IOOut_REQ); end
    clk_en = 1'b0;
    #1;
    checks++; if (ioBus.IOOut_REQ !== 1'b0) begin errors++; $display("FAIL clken_req got=%b exp=0", ioBus.IOOut_REQ); end
    clk_en = 1'b1;
  endtask

  task automatic test_write_read();
    doWrite(11'h123, 16'hBEEF, 1'b0);
    driveRead(11'h123, 4'd5, 1'b0);
    #1;
    checks++; if (ioBus.IOOut_REQ !== 1'b1) begin errors++; $display("FAIL wr_rd_req got=%b exp=1", ioBus.IOOut_REQ); end
    step();
    ioIdle();
    #1;
    checks++; if (ioBus.IOIn_ACK !== 1'b0) begin errors++; $display("FAIL wr_rd_ack_c1 got=%b exp=0", ioBus.IOIn_ACK); end
    checks++; if (RespCount !== CNT_W'(1)) begin errors++; $display("FAIL wr_rd_count_c1 got=%0d exp=1", RespCount); end
    step();
    checks++; if (ioBus.IOIn_ACK !== 1'b1) begin errors++; $display("FAIL wr_rd_ack_c2 got=%b exp=1", ioBus.IOIn_ACK); end
    checks++; if (ioBus.IOIn_DestReg !== 4'd5) begin errors++; $display("FAIL wr_rd_tag got=%0d exp=5", ioBus.IOIn_DestReg); end
    checks++; if (ioBus.IOIn_Data !== 32'h0000BEEF) begin errors++; $display("FAIL wr_rd_data got=%h exp=0000beef", ioBus.IOIn_Data); end
    ioBus.IOIn_REQ = 1'b1;
    step();
    ioBus.IOIn_REQ = 1'b0;
    checks++; if (ioBus.IOIn_ACK !== 1'b0 || RespCount !== '0) begin errors++; $display("FAIL wr_rd_pop got=%b/%0d exp=0/0", ioBus.IOIn_ACK, RespCount); end
  endtask

  task automatic test_backpressure();
    logic [DEST_W-1:0] expTag [4];
    logic [DATA_W-1:0] expData [4];
    for (int i = 0; i < 4; i++) doWrite(11'h040 + 11'(i), 16'h4000 + 16'(i), 1'b0);
    ioBus.IOIn_REQ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      driveRead(11'h040 + 11'(i), 4'(i + 1), 1'b0);
      #1;
      checks++; if (ioBus.IOOut_REQ !== 1'b1) begin errors++; $display("FAIL bp_accept%0d got=%b exp=1", i, ioBus.IOOut_REQ); end
      step();
    end
    driveRead(11'h020, 4'd9, 1'b0);
    #1;
    checks++; if (RespCount !== CNT_W'(4)) begin errors++; $display("FAIL bp_count_full got=%0d exp=4", RespCount); end
    checks++; if (ioBus.IOOut_REQ !== 1'b0) begin errors++; $display("FAIL bp_req_full got=%b exp=0", ioBus.IOOut_REQ); end
    step();
    checks++; if (RespCount !== CNT_W'(4)) begin errors++; $display("FAIL bp_count_hold got=%0d exp=4", RespCount); end
    driveWrite(11'h020, 16'h2222, 1'b0);
    #1;
    checks++; if (ioBus.IOOut_REQ !== 1'b1) begin errors++; $display("FAIL bp_write_req got=%b exp=1", ioBus.IOOut_REQ); end
    step();
    driveRead(11'h020, 4'd6, 1'b0);
    ioBus.IOIn_REQ = 1'b1;
    #1;
    checks++; if (ioBus.IOOut_REQ !== 1'b0) begin errors++; $display("FAIL bp_req_pop_same got=%b exp=0", ioBus.IOOut_REQ); end
    checks++; if (ioBus.IOIn_DestReg !== 4'd1) begin errors++; $display("FAIL bp_head1 got=%0d exp=1", ioBus.IOIn_DestReg); end
    step();
    ioBus.IOIn_REQ = 1'b0;
    #1;
    checks++; if (RespCount !== CNT_W'(3)) begin errors++; $display("FAIL bp_count_after_pop got=%0d exp=3", RespCount); end
    checks++; if (ioBus.IOOut_REQ !== 1'b1) begin errors++; $display("FAIL bp_req_after_pop got=%b exp=1", ioBus.IOOut_REQ); end
    step();
    ioIdle();
    expTag  = '{4'd2, 4'd3, 4'd4, 4'd6};
    expData = '{16'h4001, 16'h4002, 16'h4003, 16'h2222};
    ioBus.IOIn_REQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ioBus.IOIn_ACK !== 1'b1 || ioBus.IOIn_DestReg !== expTag[i] || ioBus.IOIn_Data !== {16'h0, expData[i]}) begin
        errors++;
        $display("FAIL bp_drain%0d got=%b/%0d/%h exp=1/%0d/%h", i, ioBus.IOIn_ACK, ioBus.IOIn_DestReg, ioBus.IOIn_Data, expTag[i], expData[i]);
      end
      step();
    end
    ioBus.IOIn_REQ = 1'b0;
    checks++; if (RespCount !== '0 || ioBus.IOIn_ACK !== 1'b0) begin errors++; $display("FAIL bp_empty got=%0d/%b exp=0/0", RespCount, ioBus.IOIn_ACK); end
  endtask

  task automatic test_flash();
    FlashReadEn = 1'b1;
    FlashAddrIn = 11'h123;
    driveRead(11'h123, 4'd7, 1'b0);
    #1;
    checks++; if (ioBus.IOOut_REQ !== 1'b0) begin errors++; $display("FAIL flash_io_req got=%b exp=0", ioBus.IOOut_REQ); end
    step();
    FlashReadEn = 1'b0;
    ioIdle();
    checks++; if (FlashData !== 16'hBEEF || FlashDataValid !== 1'b1) begin errors++; $display("FAIL flash_read got=%h/%b exp=beef/1", FlashData, FlashDataValid); end
    checks++; if (RespCount !== '0) begin errors++; $display("FAIL flash_no_io got=%0d exp=0", RespCount); end
    step();
    checks++; if (FlashDataValid !== 1'b0 || FlashData !== 16'hBEEF) begin errors++; $display("FAIL flash_hold got=%h/%b exp=beef/0", FlashData, FlashDataValid); end
  endtask

  task automatic test_flash_collision();
    doWrite(11'h010, 16'h0AAA, 1'b0);
    driveWrite(11'h010, 16'h1111, 1'b0);
    FlashReadEn = 1'b1;
    FlashAddrIn = 11'h010;
    #1;
    checks++; if (ioBus.IOOut_REQ !== 1'b1) begin errors++; $display("FAIL coll_write_req got=%b exp=1", ioBus.IOOut_REQ); end
    step();
    ioIdle();
    checks++; if (FlashData !== 16'h0AAA) begin errors++; $display("FAIL coll_old got=%h exp=0aaa", FlashData); end
    step();
    checks++; if (FlashData !== 16'h1111) begin errors++; $display("FAIL coll_new got=%h exp=1111", FlashData); end
    FlashReadEn = 1'b0;
  endtask

  task automatic test_async_reset();
    doWrite(11'h030, 16'h3333, 1'b0);
    ioBus.IOIn_REQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      driveRead(11'h030, 4'(i + 10), 1'b0);
      step();
    end
    ioIdle();
    step();
    checks++; if (RespCount !== CNT_W'(3) || ioBus.IOIn_ACK !== 1'b1) begin errors++; $display("FAIL arst_pre got=%0d/%b exp=3/1", RespCount, ioBus.IOIn_ACK); end
    #2;
    async_rst = 1'b1;
    #1;
    checks++; if (ioBus.IOIn_ACK !== 1'b0 || RespCount !== '0) begin errors++; $display("FAIL arst_drop got=%b/%0d exp=0/0", ioBus.IOIn_ACK, RespCount); end
    checks++; if (ioBus.IOIn_DestReg !== '0 || ioBus.IOIn_Data !== '0) begin errors++; $display("FAIL arst_out got=%h/%h exp=0/0", ioBus.IOIn_DestReg, ioBus.IOIn_Data); end
    driveWrite(11'h030, 16'h5555, 1'b0);
    step();
    ioIdle();
    async_rst = 1'b0;
    FlashReadEn = 1'b1;
    FlashAddrIn = 11'h030;
    step();
    FlashReadEn = 1'b0;
    checks++; if (FlashData !== 16'h3333) begin errors++; $display("FAIL arst_write_discard got=%h exp=3333", FlashData); end
  endtask

`ifdef IO_FLASH_BANK_AUTOINC_EN
  task automatic test_autoinc();
    doWrite(11'h7FF, 16'hA7FF, 1'b0);
    doWrite(11'h555, 16'hB000, 1'b1);
    doWrite(11'h555, 16'hB001, 1'b1);
    FlashReadEn = 1'b1;
    FlashAddrIn = 11'h000;
    step();
    checks++; if (FlashData !== 16'hB000) begin errors++; $display("FAIL auto_wrap0 got=%h exp=b000", FlashData); end
    FlashAddrIn = 11'h001;
    step();
    checks++; if (FlashData !== 16'hB001) begin errors++; $display("FAIL auto_wrap1 got=%h exp=b001", FlashData); end
    FlashAddrIn = 11'h7FF;
    step();
    checks++; if (FlashData !== 16'hA7FF) begin errors++; $display("FAIL auto_base got=%h exp=a7ff", FlashData); end
    FlashReadEn = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [DATA_W-1:0] mMem [32];
    exp_t              q [$];
    exp_t              e;
    int                mPtr;
    logic [DATA_W-1:0] mFlashData;
    logic              mFlashValid;
    logic              ce, fre, ack, rr, autoBit, ireq;
    logic [ADDR_W-1:0] fAddr, fieldAddr;
    logic [DEST_W-1:0] tag;
    logic [DATA_W-1:0] wd;
    logic              expReq, expAck, hs, pop;
    int                addr;
    logic [DEST_W-1:0] expTag;
    logic [31:0]       expData;

    applyReset();
    mPtr = 0;
    for (int a = 0; a < 32; a++) begin
      wd = 16'($urandom);
      mMem[a] = wd;
      doWrite(11'(a), wd, 1'b0);
      mPtr = a + 1;
    end
    mFlashData = '0;
    mFlashValid = 1'b0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      ce        = ($urandom_range(0, 7) != 0);
      fre       = ($urandom_range(0, 3) == 0);
      fAddr     = 11'($urandom_range(0, 31));
      ack       = 1'($urandom_range(0, 1));
      rr        = 1'($urandom_range(0, 1));
      tag       = 4'($urandom);
      fieldAddr = 11'($urandom_range(0, 31));
      wd        = 16'($urandom);
      autoBit   = 1'($urandom_range(0, 1));
      if (AUTO_EN && mPtr > 31) autoBit = 1'b0;
      ireq      = ($urandom_range(0, 2) != 0);

      clk_en = ce;
      FlashReadEn = fre;
      FlashAddrIn = fAddr;
      ioBus.IOOut_ACK = ack;
      ioBus.IOOut_ResponseRequested = rr;
      ioBus.IOOut_DestReg = tag;
      ioBus.IOOut_Data = ioWord(fieldAddr, wd, autoBit);
      ioBus.IOIn_REQ = ireq;
      #1;

      expAck  = (q.size() > 0) && q[0].queued;
      expReq  = ce && (rr ? (!fre && q.size() < RESP_DEPTH) : 1'b1);
      expTag  = expAck ? q[0].tag : '0;
      expData = expAck ? {16'h0, q[0].data} : '0;
      checks++; if (ioBus.IOOut_REQ !== expReq) begin errors++; $display("FAIL rnd_req c%0d got=%b exp=%b", cyc, ioBus.IOOut_REQ, expReq); end
      checks++; if (ioBus.IOIn_ACK !== expAck) begin errors++; $display("FAIL rnd_ack c%0d got=%b exp=%b", cyc, ioBus.IOIn_ACK, expAck); end
      checks++; if (RespCount !== CNT_W'(q.size())) begin errors++; $display("FAIL rnd_count c%0d got=%0d exp=%0d", cyc, RespCount, q.size()); end
      checks++; if (ioBus.IOIn_DestReg !== expTag) begin errors++; $display("FAIL rnd_tag c%0d got=%0d exp=%0d", cyc, ioBus.IOIn_DestReg, expTag); end
      checks++; if (ioBus.IOIn_Data !== expData) begin errors++; $display("FAIL rnd_data c%0d got=%h exp=%h", cyc, ioBus.IOIn_Data, expData); end
      checks++; if (FlashData !== mFlashData) begin errors++; $display("FAIL rnd_flash c%0d got=%h exp=%h", cyc, FlashData, mFlashData); end
      checks++; if (FlashDataValid !== mFlashValid) begin errors++; $display("FAIL rnd_fvalid c%0d got=%b exp=%b", cyc, FlashDataValid, mFlashValid); end

      if (ce) begin
        addr = (AUTO_EN && autoBit) ? mPtr : int'(fieldAddr);
        hs   = ack && expReq;
        pop  = expAck && ireq;
        if (fre) mFlashData = mMem[fAddr[4:0]];
        mFlashValid = fre;
        if (pop) void'(q.pop_front());
        foreach (q[i]) q[i].queued = 1'b1;
        if (hs && rr) begin
          e.tag = tag;
          e.data = mMem[addr];
          e.queued = 1'b0;
          q.push_back(e);
        end
        if (hs && !rr) mMem[addr] = wd;
        if (hs) mPtr = (addr + 1) % (2 ** ADDR_W);
      end
      step();
    end
    clk_en = 1'b1;
    FlashReadEn = 1'b0;
    ioBus.IOIn_REQ = 1'b0;
    ioIdle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_flash();
    test_flash_collision();
    test_async_reset();
`ifdef IO_FLASH_BANK_AUTOINC_EN
    test_autoinc();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
